// File: rtl/bist_pkg.sv
// Shared definitions for the LBIST session sequencer: state codes, default
// parameter values and the saturating increment used by the statistic counters.
package bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_NEXT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int DEF_ERR_BITS     = 8;
    localparam int DEF_FAULT_BITS   = 8;
    localparam int DEF_PAT_BITS     = 16;
    localparam int DEF_SETUP_CYCLES = 12;

    // Increments value by one unless it has already reached limit (widths up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Session interface of the LBIST sequencer: software handshake, TPG/ORA/fault-list
// controls, statistics and the debug view of the sequencer state.
interface bist_sequencer_if #(
    parameter int ERR_BITS   = bist_pkg::DEF_ERR_BITS,
    parameter int FAULT_BITS = bist_pkg::DEF_FAULT_BITS,
    parameter int PAT_BITS   = bist_pkg::DEF_PAT_BITS
);
    import bist_pkg::*;

    // Handshake: start is a level request sampled only while the sequencer is idle
    // (busy=0); busy stays high for the whole session and done pulses for exactly one
    // cycle when it ends, after which a new start is accepted.
    logic                  start;
    logic                  abort;
    logic                  stop_on_fail;
    logic [PAT_BITS-1:0]   max_patterns;
    logic                  tpg_end;
    logic                  ora_res;
    logic                  fil_end;

    logic                  cut_reset;
    logic                  tpg_reset;
    logic                  tpg_en;
    logic                  fil_inc;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [ERR_BITS-1:0]   err_count;
    logic [FAULT_BITS-1:0] faults_tested;
    logic [FAULT_BITS-1:0] faults_detected;
    state_t                state;

    modport master (
        output start, abort, stop_on_fail, max_patterns, tpg_end, ora_res, fil_end,
        input  cut_reset, tpg_reset, tpg_en, fil_inc, busy, done, aborted,
        input  err_count, faults_tested, faults_detected, state
    );

    modport slave (
        input  start, abort, stop_on_fail, max_patterns, tpg_end, ora_res, fil_end,
        output cut_reset, tpg_reset, tpg_en, fil_inc, busy, done, aborted,
        output err_count, faults_tested, faults_detected, state
    );

endinterface

// File: rtl/sat_counter.sv
// Statistic counter: synchronous clear, increment on request, holds at all-ones.
module sat_counter
    import bist_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ALL_ONES = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= W'(sat_inc(32'(count), 32'(ALL_ONES)));
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// LBIST session sequencer: walks the fault list, giving each fault a reset/setup
// window and a pattern run, and gathers mismatch and fault statistics.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int ERR_BITS     = DEF_ERR_BITS,
    parameter int FAULT_BITS   = DEF_FAULT_BITS,
    parameter int PAT_BITS     = DEF_PAT_BITS,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    bist_sequencer_if.slave bus
);

    localparam int             SW         = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SW-1:0]  SETUP_LAST = SW'(SETUP_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [SW-1:0]       setup_cnt;
    logic [PAT_BITS-1:0] pat_cnt;
    logic [PAT_BITS-1:0] pat_num;
    logic                detect;
    logic                aborted_q;

    logic                in_session;
    logic                abort_hit;
    logic                run_exit;
    logic                stat_clr;
    logic                err_inc;
    logic                fault_done;
    logic                setup_entry;

    // pat_num is the 1-based number of the pattern being applied this RUN cycle.
    assign pat_num     = pat_cnt + PAT_BITS'(1);
    assign in_session  = (state == ST_SETUP) || (state == ST_RUN) || (state == ST_NEXT);
    assign abort_hit   = bus.abort && in_session;
    assign run_exit    = bus.tpg_end
                      || ((bus.max_patterns != '0) && (pat_num == bus.max_patterns))
                      || (bus.stop_on_fail && bus.ora_res);
    assign stat_clr    = (state == ST_IDLE) && bus.start;
    assign err_inc     = (state == ST_RUN) && bus.ora_res && !bus.abort;
    assign fault_done  = (state == ST_NEXT) && !bus.abort;
    assign setup_entry = (state_nxt == ST_SETUP) && (state != ST_SETUP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SETUP;
            ST_SETUP: if (setup_cnt == SETUP_LAST) state_nxt = ST_RUN;
            ST_RUN:   if (run_exit) state_nxt = ST_NEXT;
            ST_NEXT:  state_nxt = bus.fil_end ? ST_DONE : ST_SETUP;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            setup_cnt <= '0;
            pat_cnt   <= '0;
            detect    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state <= state_nxt;

            // Every fault run starts from a fresh setup window, pattern count and flag.
            if (setup_entry) begin
                setup_cnt <= '0;
                pat_cnt   <= '0;
                detect    <= 1'b0;
            end else if (state == ST_SETUP) begin
                setup_cnt <= setup_cnt + SW'(1);
            end

            if ((state == ST_RUN) && !bus.abort) begin
                pat_cnt <= pat_num;
                if (bus.ora_res) detect <= 1'b1;
            end

            if (stat_clr) begin
                aborted_q <= 1'b0;
            end else if (abort_hit) begin
                aborted_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(ERR_BITS)) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (err_inc),
        .count (bus.err_count)
    );

    sat_counter #(.W(FAULT_BITS)) u_faults_tested (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (fault_done),
        .count (bus.faults_tested)
    );

    sat_counter #(.W(FAULT_BITS)) u_faults_detected (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (fault_done && detect),
        .count (bus.faults_detected)
    );

    assign bus.cut_reset = (state == ST_IDLE) || (state == ST_SETUP) || (state == ST_DONE);
    assign bus.tpg_reset = (state != ST_RUN);
    assign bus.tpg_en    = (state == ST_RUN);
    // An abort landing in NEXT must not advance the fault list.
    assign bus.fil_inc   = fault_done;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.aborted   = aborted_q;
    assign bus.state     = state;

endmodule
